// File: rtl/tour_move_sequencer_pkg.sv
// Shared command constants, FSM state type and the knight-move decoder for the tour sequencer.
package knight_pkg;

  localparam logic [3:0] MOVE_OP     = 4'h2;
  localparam logic [3:0] MOVE_FAN_OP = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_E = 8'hBF;

  typedef enum logic [2:0] {StIdle, StVert, StWaitV, StHorz, StWaitH} state_t;

  typedef struct packed {
    logic [15:0] vert;
    logic [15:0] horz;
  } leg_cmds_t;

  // Any pattern that is not exactly one-hot falls back to move bit 0.
  function automatic leg_cmds_t decode_move(input logic [7:0] move);
    leg_cmds_t c;
    case (move)
      8'h02:   begin c.vert = {MOVE_OP, HDG_N, 4'd2}; c.horz = {MOVE_FAN_OP, HDG_W, 4'd1}; end
      8'h04:   begin c.vert = {MOVE_OP, HDG_N, 4'd1}; c.horz = {MOVE_FAN_OP, HDG_W, 4'd2}; end
      8'h08:   begin c.vert = {MOVE_OP, HDG_S, 4'd1}; c.horz = {MOVE_FAN_OP, HDG_W, 4'd2}; end
      8'h10:   begin c.vert = {MOVE_OP, HDG_S, 4'd2}; c.horz = {MOVE_FAN_OP, HDG_W, 4'd1}; end
      8'h20:   begin c.vert = {MOVE_OP, HDG_S, 4'd2}; c.horz = {MOVE_FAN_OP, HDG_E, 4'd1}; end
      8'h40:   begin c.vert = {MOVE_OP, HDG_S, 4'd1}; c.horz = {MOVE_FAN_OP, HDG_E, 4'd2}; end
      8'h80:   begin c.vert = {MOVE_OP, HDG_N, 4'd1}; c.horz = {MOVE_FAN_OP, HDG_E, 4'd2}; end
      default: begin c.vert = {MOVE_OP, HDG_N, 4'd2}; c.horz = {MOVE_FAN_OP, HDG_E, 4'd1}; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tour_move_sequencer_if.sv
// Command-path bundle between TourLogic/UART_wrapper/cmd_proc and the tour sequencer.
interface tour_move_sequencer_if #(
  parameter int unsigned IDX_W = 5
);
  logic             start_tour;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy;
  logic             send_resp;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic             usurp;
  logic [7:0]       resp;

  modport master (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, cmd, cmd_rdy, usurp, resp
  );

  modport slave (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, cmd, cmd_rdy, usurp, resp
  );
endinterface

// File: rtl/tour_move_sequencer.sv
// Replays the solved knight's tour as vertical/horizontal command pairs, taking the command
// path from UART for the duration of the tour.
module tour_move_sequencer
  import knight_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 24,
  parameter int unsigned IDX_W     = 5
) (
  input logic                   clk,
  input logic                   rst,
  tour_move_sequencer_if.master bus
);

  state_t           state_q;
  logic [IDX_W-1:0] mv_indx_q;
  logic             usurp_q;
  logic             cmd_rdy_q;
  logic             last_move;
  leg_cmds_t        legs;
  logic [15:0]      fsm_cmd;

  assign last_move = (mv_indx_q == IDX_W'(NUM_MOVES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mv_indx_q <= '0;
      usurp_q   <= 1'b0;
      cmd_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (bus.start_tour) begin
          state_q   <= StVert;
          mv_indx_q <= '0;
          usurp_q   <= 1'b1;
          cmd_rdy_q <= 1'b1;
        end
        StVert: if (bus.clr_cmd_rdy) begin
          state_q   <= StWaitV;
          cmd_rdy_q <= 1'b0;
        end
        StWaitV: if (bus.send_resp) begin
          state_q   <= StHorz;
          cmd_rdy_q <= 1'b1;
        end
        StHorz: if (bus.clr_cmd_rdy) begin
          state_q   <= StWaitH;
          cmd_rdy_q <= 1'b0;
        end
        StWaitH: if (bus.send_resp) begin
          if (last_move) begin
            state_q <= StIdle;
            usurp_q <= 1'b0;
          end else begin
            state_q   <= StVert;
            mv_indx_q <= mv_indx_q + IDX_W'(1);
            cmd_rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          usurp_q   <= 1'b0;
          cmd_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // move is a lookup on mv_indx_q, so the decoded leg is stable for the whole move.
  always_comb begin
    legs    = decode_move(bus.move);
    fsm_cmd = legs.vert;
    if (state_q == StHorz || state_q == StWaitH) fsm_cmd = legs.horz;
  end

  assign bus.mv_indx = mv_indx_q;
  assign bus.usurp   = usurp_q;
  assign bus.cmd     = usurp_q ? fsm_cmd : bus.cmd_UART;
  assign bus.cmd_rdy = usurp_q ? cmd_rdy_q : bus.cmd_rdy_UART;
  assign bus.resp    = (usurp_q && !last_move) ? 8'h5A : 8'hA5;

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Randomized tour replay against a move-table reference model with a scoreboard monitor.
module tb_tour_move_sequencer;

  localparam int NUM = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tour_move_sequencer_if #(.IDX_W(5)) bus ();

  tour_move_sequencer #(.NUM_MOVES(NUM), .IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] cmd;
    logic [4:0]  idx;
    logic [7:0]  resp;
  } exp_t;

  int   checks    = 0;
  int   failures  = 0;
  int   legs_seen = 0;
  exp_t exp_q[$];
  logic [7:0] moves [NUM];
  logic prev_leg = 1'b0;

  // TourLogic stand-in: combinational lookup of the solved move at mv_indx.
  always_comb begin
    bus.move = 8'h00;
    if (int'(bus.mv_indx) < NUM) bus.move = moves[bus.mv_indx];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Knight displacement per move bit; commands built from signs and magnitudes.
  function automatic void model_legs(input logic [7:0] m, output logic [15:0] v,
                                     output logic [15:0] h);
    int dy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int b = 0;
    if ($onehot(m)) for (int i = 0; i < 8; i++) if (m[i]) b = i;
    v = {4'h2, (dy[b] > 0) ? 8'h00 : 8'h7F, 4'((dy[b] > 0) ? dy[b] : -dy[b])};
    h = {4'h3, (dx[b] > 0) ? 8'hBF : 8'h3F, 4'((dx[b] > 0) ? dx[b] : -dx[b])};
  endfunction

  task automatic push_expected;
    exp_t e;
    logic [15:0] v, h;
    for (int i = 0; i < NUM; i++) begin
      model_legs(moves[i], v, h);
      e.idx  = 5'(i);
      e.resp = (i == NUM - 1) ? 8'hA5 : 8'h5A;
      e.cmd  = v;
      exp_q.push_back(e);
      e.cmd  = h;
      exp_q.push_back(e);
    end
  endtask

  task automatic randomize_moves;
    for (int i = 0; i < NUM; i++) begin
      if ($urandom_range(7) == 0) moves[i] = 8'($urandom);
      else moves[i] = 8'h01 << $urandom_range(7);
    end
  endtask

  // Monitor: every new command offered on the tour path is scored against the queue.
  initial begin
    exp_t e;
    logic now;
    forever begin
      @(negedge clk);
      now = bus.usurp && bus.cmd_rdy && !rst;
      if (now && !prev_leg) begin
        legs_seen++;
        if (exp_q.size() == 0) chk("unexpected_leg", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("leg_cmd", bus.cmd, e.cmd);
          chk("leg_mv_indx", bus.mv_indx, e.idx);
          chk("leg_resp", bus.resp, e.resp);
        end
      end
      prev_leg = now;
    end
  end

  // cmd_proc model; abort_leg >= 0 asserts rst in the WAIT after that leg is taken.
  task automatic run_tour(input int abort_leg, input bit directed);
    int n;
    logic [15:0] held;
    logic [15:0] dir_cmd [4] = '{16'h2002, 16'h3BF1, 16'h27F1, 16'h33F2};
    push_expected();
    legs_seen = 0;
    bus.start_tour = 1'b1;
    tick();
    bus.start_tour = 1'b0;
    chk("start_latency_rdy", bus.cmd_rdy, 32'd1);
    chk("start_usurp", bus.usurp, 32'd1);
    for (int k = 0; k < 2 * NUM; k++) begin
      n = 0;
      while (!(bus.usurp && bus.cmd_rdy) && n < 20) begin tick(); n++; end
      if (n >= 20) begin
        chk("leg_timeout", 32'd0, 32'd1);
        return;
      end
      if (directed && k < 4) chk("directed_cmd", bus.cmd, dir_cmd[k]);
      repeat ($urandom_range(2)) tick();
      bus.cmd_rdy_UART = 1'b1;
      bus.clr_cmd_rdy  = 1'b1;
      tick();
      bus.clr_cmd_rdy  = 1'b0;
      chk("wait_rdy_low", bus.cmd_rdy, 32'd0);
      if (k == abort_leg) begin
        chk("abort_mv_indx_before", bus.mv_indx, 32'(k / 2));
        rst = 1'b1;
        #1;
        chk("abort_usurp", bus.usurp, 32'd0);
        chk("abort_mv_indx", bus.mv_indx, 32'd0);
        chk("abort_cmd_uart", bus.cmd, bus.cmd_UART);
        chk("abort_resp", bus.resp, 32'hA5);
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        return;
      end
      if (k == 4) begin
        held = bus.cmd;
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        chk("start_in_wait_idx", bus.mv_indx, 32'd2);
        chk("start_in_wait_rdy", bus.cmd_rdy, 32'd0);
        chk("start_in_wait_cmd", bus.cmd, held);
      end
      repeat ($urandom_range(2)) tick();
      bus.send_resp = 1'b1;
      if (k % 2 == 1 && (k == 9 || $urandom_range(1) == 1)) bus.clr_cmd_rdy = 1'b1;
      if (k == 2 * NUM - 1) chk("usurp_at_last_resp", bus.usurp, 32'd1);
      tick();
      bus.send_resp   = 1'b0;
      bus.clr_cmd_rdy = 1'b0;
      if (k == 2 * NUM - 1) begin
        chk("usurp_after_last", bus.usurp, 32'd0);
        chk("mv_indx_final", bus.mv_indx, 32'(NUM - 1));
      end else begin
        chk("resp_latency_rdy", bus.cmd_rdy, 32'd1);
      end
      bus.cmd_rdy_UART = 1'($urandom_range(1));
    end
    tick();
    chk("mv_indx_hold", bus.mv_indx, 32'(NUM - 1));
    chk("legs_issued", 32'(legs_seen), 32'(2 * NUM));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start_tour   = 1'b0;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;
    bus.cmd_UART     = 16'h4022;
    bus.cmd_rdy_UART = 1'b1;
    randomize_moves();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_usurp", bus.usurp, 32'd0);
    chk("reset_cmd", bus.cmd, 32'h4022);
    chk("reset_cmd_rdy", bus.cmd_rdy, 32'd1);
    chk("reset_resp", bus.resp, 32'hA5);
    chk("reset_mv_indx", bus.mv_indx, 32'd0);

    moves[0] = 8'h01;
    moves[1] = 8'h08;
    run_tour(-1, 1'b1);

    randomize_moves();
    bus.cmd_UART = 16'($urandom);
    run_tour(15, 1'b0);
    chk("post_abort_usurp", bus.usurp, 32'd0);

    randomize_moves();
    run_tour(-1, 1'b0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
